// File: rtl/exi_tx_if.sv
// ============================================================================
// Module   : exi_tx_if
// Brief    : EXI pin bundle (sck/cs/miso) plus the DPRAM read port of exi_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exi_tx_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              sck;
   logic              cs;
   logic              miso;
   logic              miso_oe;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rd;
   logic [DATA_W-1:0] ram_rdata;

   // The environment drives the EXI pins and the RAM data
   modport master (
      output sck, cs, ram_rdata,
      input  miso, miso_oe, ram_addr, ram_rd
   );

   modport slave (
      input  sck, cs, ram_rdata,
      output miso, miso_oe, ram_addr, ram_rd
   );
endinterface

`default_nettype wire

// File: rtl/exi_tx.sv
// ============================================================================
// Module   : exi_tx
// Brief    : EXI slave transmitter, mode 0, MSB-first, one-byte RAM look-ahead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exi_tx #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   exi_tx_if.slave           exi,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              byte_done,
   output logic [7:0]        tx_count,
   output logic              underrun
);

   localparam int                 c_CNT_W   = $clog2(DATA_W);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   state_t              r_state;
   logic [2:0]          r_sck_sync;
   logic [2:0]          r_cs_sync;
   logic [DATA_W-1:0]   r_shreg;
   logic [DATA_W-1:0]   r_next;
   logic                r_next_valid;
   logic                r_byte_cmpl;
   logic [c_CNT_W-1:0]  r_bit_cnt;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic                r_ram_rd;
   logic                r_miso;
   logic                r_miso_oe;
   logic                r_byte_done;
   logic [7:0]          r_tx_count;
   logic                r_underrun;

   logic w_sck_rise;
   logic w_sck_fall;
   logic w_start;
   logic w_end;
   logic w_cs_active;

   assign w_sck_rise  = (r_sck_sync[2:1] == 2'b01);
   assign w_sck_fall  = (r_sck_sync[2:1] == 2'b10);
   assign w_start     = (r_cs_sync[2:1] == 2'b10);
   assign w_end       = (r_cs_sync[2:1] == 2'b01);
   assign w_cs_active = ~r_cs_sync[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_sck_sync   <= '0;
         r_cs_sync    <= '0;
         r_shreg      <= '0;
         r_next       <= '0;
         r_next_valid <= 1'b0;
         r_byte_cmpl  <= 1'b0;
         r_bit_cnt    <= c_CNT_MAX;
         r_ram_addr   <= '0;
         r_ram_rd     <= 1'b0;
         r_miso       <= 1'b0;
         r_miso_oe    <= 1'b0;
         r_byte_done  <= 1'b0;
         r_tx_count   <= '0;
         r_underrun   <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[1:0], exi.sck};
         r_cs_sync   <= {r_cs_sync[1:0], exi.cs};
         r_ram_rd    <= 1'b0;
         r_byte_done <= 1'b0;

         // A cs fall always (re)starts the message, whatever state we are in
         if (w_start) begin
            r_ram_addr  <= base_addr;
            r_ram_rd    <= 1'b1;
            r_tx_count  <= '0;
            r_underrun  <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_state     <= S_LOAD;
         end else if (w_end && (r_state != S_IDLE)) begin
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_next_valid <= 1'b0;
            r_byte_cmpl  <= 1'b0;
            r_state      <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_miso    <= 1'b0;
                  r_miso_oe <= 1'b0;
               end

               S_LOAD: begin
                  r_shreg      <= exi.ram_rdata;
                  r_miso       <= 1'b0;
                  r_miso_oe    <= 1'b1;
                  r_bit_cnt    <= c_CNT_MAX;
                  r_next_valid <= 1'b0;
                  r_byte_cmpl  <= 1'b0;
                  r_state      <= S_SHIFT;
               end

               S_SHIFT: begin
                  r_miso <= r_shreg[DATA_W-1];
                  if (w_cs_active && w_sck_rise) begin
                     if (r_bit_cnt == '0) begin
                        r_bit_cnt   <= c_CNT_MAX;
                        r_byte_cmpl <= 1'b1;
                        r_byte_done <= 1'b1;
                        if (r_tx_count != 8'hFF) begin
                           r_tx_count <= r_tx_count + 8'd1;
                        end
                        // A still-unconsumed look-ahead byte blocks the next read
                        if (!r_next_valid) begin
                           r_ram_addr <= r_ram_addr + ADDR_W'(1);
                           r_ram_rd   <= 1'b1;
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt - c_CNT_W'(1);
                     end
                  end
                  if (w_cs_active && w_sck_fall) begin
                     if (r_byte_cmpl) begin
                        r_byte_cmpl <= 1'b0;
                        if (r_next_valid) begin
                           r_shreg      <= r_next;
                           r_next_valid <= 1'b0;
                        end else begin
                           r_shreg    <= '1;
                           r_underrun <= 1'b1;
                        end
                     end else if (r_bit_cnt != c_CNT_MAX) begin
                        r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                     end
                  end
                  // Late-arriving read data still lands even on an underrun fall
                  if (r_ram_rd) begin
                     r_next       <= exi.ram_rdata;
                     r_next_valid <= 1'b1;
                  end
               end

               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign exi.miso     = r_miso;
   assign exi.miso_oe  = r_miso_oe;
   assign exi.ram_addr = r_ram_addr;
   assign exi.ram_rd   = r_ram_rd;
   assign byte_done    = r_byte_done;
   assign tx_count     = r_tx_count;
   assign underrun     = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_exi_tx.sv
// ============================================================================
// Module   : tb_exi_tx
// Brief    : Randomized self-checking bench for exi_tx acting as an EXI host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_exi_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] base_addr = 8'h00;
   logic       byte_done;
   logic [7:0] tx_count;
   logic       underrun;

   exi_tx_if #(.DATA_W(8), .ADDR_W(8)) bus ();

   exi_tx #(.DATA_W(8), .ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .exi       (bus),
      .base_addr (base_addr),
      .byte_done (byte_done),
      .tx_count  (tx_count),
      .underrun  (underrun)
   );

   logic [7:0] mem [256];
   assign bus.ram_rdata = mem[bus.ram_addr];

   always #5 clk = ~clk;

   int         n_vec  = 0;
   int         n_err  = 0;
   logic [7:0] rd_q[$];
   int         bd_cnt = 0;
   bit         oe_seen = 1'b0;

   always @(negedge clk) begin
      if (bus.ram_rd) rd_q.push_back(bus.ram_addr);
      if (byte_done) bd_cnt++;
      if (bus.miso_oe) oe_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Host samples miso just before raising sck, as a mode-0 master would
   task automatic sck_pulse(input int half, output logic b);
      repeat (half) @(negedge clk);
      b = bus.miso;
      bus.sck = 1'b1;
      repeat (half) @(negedge clk);
      bus.sck = 1'b0;
   endtask

   task automatic host_byte(input int half, output logic [7:0] b);
      logic bt;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         sck_pulse(half, bt);
         b = {b[6:0], bt};
      end
   endtask

   task automatic msg_begin(input logic [7:0] base);
      base_addr = base;
      bus.cs    = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic msg_end();
      bus.cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic fill(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) mem[8'(base + 8'(i))] = 8'($urandom);
   endtask

   task automatic run_msg(input string tag, input logic [7:0] base, input int n);
      logic [7:0] b;
      int         bd0;
      rd_q.delete();
      bd0 = bd_cnt;
      msg_begin(base);
      for (int i = 0; i < n; i++) begin
         host_byte(4, b);
         chk($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(mem[8'(base + 8'(i))]));
      end
      msg_end();
      chk({tag, "_tx_count"}, 32'(tx_count), 32'(n));
      chk({tag, "_byte_done"}, 32'(bd_cnt - bd0), 32'(n));
      chk({tag, "_underrun"}, 32'(underrun), 32'd0);
      chk({tag, "_rd_count"}, 32'(rd_q.size()), 32'(n + 1));
      for (int i = 0; i < rd_q.size() && i <= n; i++)
         chk($sformatf("%s_rd_addr%0d", tag, i), 32'(rd_q[i]), 32'(8'(base + 8'(i))));
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] b;
      logic [7:0] base;
      logic       bt;
      int         n;
      logic [7:0] tc0;

      bus.sck = 1'b0;
      bus.cs  = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset_outs", 32'({bus.miso, bus.miso_oe, bus.ram_rd, byte_done, underrun, tx_count, bus.ram_addr}), 32'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      mem[8'h10] = 8'hA5;
      run_msg("single", 8'h10, 1);

      mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
      run_msg("wrap", 8'hFE, 4);

      for (int k = 0; k < 6; k++) begin
         base = 8'($urandom);
         n    = $urandom_range(1, 5);
         fill(base, n + 1);
         run_msg($sformatf("rand%0d", k), base, n);
      end

      // Abort in the middle of the second byte
      base = 8'($urandom);
      fill(base, 3);
      msg_begin(base);
      host_byte(4, b);
      chk("abort_byte0", 32'(b), 32'(mem[base]));
      for (int i = 0; i < 3; i++) sck_pulse(4, bt);
      bus.cs = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_oe", 32'(bus.miso_oe), 32'd0);
      repeat (4) @(negedge clk);
      chk("abort_tx_count", 32'(tx_count), 32'd1);
      run_msg("restart", base, 1);

      // Underrun: fast sck outruns the look-ahead read
      base = 8'($urandom);
      fill(base, 4);
      msg_begin(base);
      host_byte(1, b);
      repeat (4) @(negedge clk);
      chk("urun_flag", 32'(underrun), 32'd1);
      chk("urun_miso", 32'(bus.miso), 32'd1);
      host_byte(4, b);
      chk("urun_ff_byte", 32'(b), 32'hFF);
      host_byte(4, b);
      chk("urun_late_byte", 32'(b), 32'(mem[8'(base + 8'd1)]));
      msg_end();
      chk("urun_tx_count", 32'(tx_count), 32'd3);
      chk("urun_hold", 32'(underrun), 32'd1);
      bus.cs = 1'b0;
      repeat (4) @(negedge clk);
      chk("urun_clear", 32'(underrun), 32'd0);
      msg_end();

      // Reset during bit 4 of the first byte
      base = 8'($urandom);
      fill(base, 3);
      msg_begin(base);
      for (int i = 0; i < 3; i++) sck_pulse(4, bt);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_outs", 32'({bus.miso, bus.miso_oe, bus.ram_rd, byte_done, underrun, tx_count, bus.ram_addr}), 32'd0);
      rst = 1'b0;
      rd_q.delete();
      oe_seen = 1'b0;
      for (int i = 0; i < 8; i++) sck_pulse(4, bt);
      repeat (4) @(negedge clk);
      chk("midrst_oe", 32'(oe_seen), 32'd0);
      chk("midrst_rd", 32'(rd_q.size()), 32'd0);
      chk("midrst_tx_count", 32'(tx_count), 32'd0);
      msg_end();
      run_msg("post_rst", base, 2);

      // sck noise with cs inactive
      rd_q.delete();
      oe_seen = 1'b0;
      tc0 = tx_count;
      for (int i = 0; i < 16; i++) sck_pulse($urandom_range(1, 4), bt);
      repeat (6) @(negedge clk);
      chk("noise_rd", 32'(rd_q.size()), 32'd0);
      chk("noise_oe", 32'(oe_seen), 32'd0);
      chk("noise_tx_count", 32'(tx_count), 32'(tc0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/exi_tx.md
Name: exi_tx

Overview:
- EXI slave transmitter: the MISO direction of the EXI capture path.
- Samples EXI sck/cs on the fast board clk and reads bytes from the DPRAM read port, starting at base_addr.
- Shifts bytes out MSB-first on MISO using mode 0 (CPOL=0, CPHA=0): MISO changes after sck falls, and the host samples it on sck rising.
- Sits beside the existing EXI receiver; both share the same sck/cs pins.

Parameters:
- DATA_W, 8, width of the shift register and of each RAM word.
- ADDR_W, 8, width of the RAM address; the address wraps modulo 2^ADDR_W.

Ports:
- clk  input  1  board clock; must be at least 4x the sck frequency.
- rst  input  1  synchronous, active-high reset.
- sck  input  1  EXI clock, asynchronous to clk.
- cs  input  1  EXI chip select, active low, asynchronous to clk.
- base_addr  input  ADDR_W  first RAM address of each message; sampled at message start.
- ram_rdata  input  DATA_W  DPRAM read data, valid 1 clk after ram_rd.
- ram_addr  output  ADDR_W  DPRAM read address.
- ram_rd  output  1  1-clk read strobe.
- miso  output  1  serial data out.
- miso_oe  output  1  MISO driver enable; high only while a message is active.
- byte_done  output  1  1-clk pulse after the 8th sck rising edge of each byte.
- tx_count  output  8  bytes fully sent in the current message; saturates at 255.
- underrun  output  1  sticky flag: the next byte was not ready when needed. Cleared at message start.

Behaviour:
- Synchronizers:
  - sck and cs each pass through a 3-flop chain.
  - Edges are decoded from stages [2:1]: rise = 01, fall = 10.
  - cs_active = !csr[1]; startmsg = cs fall; endmsg = cs rise.
- Reset values: all outputs 0; state IDLE; shift register 0; bit counter 7.
- States:
  - IDLE:
    - miso_oe=0, miso=0.
    - On startmsg: ram_addr<=base_addr, ram_rd=1, clear tx_count and underrun, go to LOAD.
  - LOAD:
    - shreg<=ram_rdata, miso_oe=1, bit counter<=7, go to SHIFT.
    - The first MSB appears on miso 2 clk after startmsg is detected.
  - SHIFT (sck edge handling):
    - miso = shreg[DATA_W-1].
    - On sck rise: bit counter decrements.
    - On the 8th rise (counter==0): pulse byte_done, tx_count++ (saturating), ram_addr<=ram_addr+1 (wraps), ram_rd=1.
    - The following clk: next<=ram_rdata, next_valid=1.
    - On sck fall with counter!=7: shreg shifts left, filling 0.
    - On sck fall after a completed byte: if next_valid, shreg<=next and next_valid=0; else shreg<=all ones and underrun<=1.
  - Leaving SHIFT:
    - endmsg from any non-IDLE state goes to IDLE the same clk.
    - A partial byte is discarded, miso_oe drops, and no ram_rd is issued.
    - tx_count and underrun hold until the next startmsg.
- Simultaneous events:
  - startmsg while not IDLE cannot occur, because cs must rise first; if glitched, restart from LOAD.
  - sck edges while cs is inactive are ignored.
- Read look-ahead: one byte (the next one); no read of the following address is issued until that byte is consumed.
- rst takes priority over all events, including a mid-message reset. After rst, the block waits for the next startmsg; it does not resume the current message.

Test Plan:
- Single byte: RAM[0x10]=0xA5, base_addr=0x10, cs low, 8 sck pulses at clk/8 -> host samples 1,0,1,0,0,1,0,1; byte_done once; tx_count=1; one ram_rd at 0x10, then one at 0x11 after the 8th rise.
- Burst with wrap: base_addr=0xFE, RAM[0xFE..0x01]=0x11,0x22,0x33,0x44, 32 sck pulses -> MISO bytes 0x11,0x22,0x33,0x44; ram_addr sequence FE,FF,00,01; tx_count=4; underrun=0.
- Abort mid-byte: cs rises after 3 sck pulses of byte 2 -> miso_oe=0 within 3 clk of the pin edge; tx_count=1; the next message restarts at base_addr with its MSB correct.
- Underrun: sck at clk/2, so the look-ahead is too slow -> the failing byte is sent as 0xFF and underrun=1; underrun clears at the next cs fall.
- Reset mid-message: assert rst during bit 4 of byte 1 -> all outputs 0 the next clk; after rst drops, further sck pulses are ignored until a new cs fall.
- Idle noise: sck toggles with cs high -> no ram_rd, miso_oe stays 0, tx_count unchanged.
